vram_arb: RTL and testbench

VRAM_ARB -- requirements
Module: vram_arb

---
 rtl/vram_pkg.sv | 12 +
 rtl/vram_arb.sv | 114 +++++++++++
 tb/tb_vram_arb.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: read-owner tag and the default starvation limit.
package vram_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CMD  = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_MAX_DEF = 4'd15;

endpackage

// File: rtl/vram_arb.sv
// Two-port (display/command) arbiter in front of a single-port VRAM with registered grants.
// Optional macro VRAM_ARB_BLANK_GATE_EN adds a blank input that confines command grants to blanking.
module vram_arb
    import vram_pkg::*;
#(
    parameter int         ADDR_W     = 13,
    parameter int         DATA_W     = 8,
    parameter logic [3:0] STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef VRAM_ARB_BLANK_GATE_EN
    input  logic              blank,
`endif
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cmd_req,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ack,
    output logic              cmd_rvalid,
    output logic [DATA_W-1:0] cmd_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic       disp_eff;
    logic       cmd_eff;
    logic       cmd_allowed;
    logic       starve_hit;
    logic       grant_disp;
    logic       grant_cmd;
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;
    owner_t     own1;
    owner_t     own2;
    owner_t     own1_nxt;

    // A request whose ack is currently high is the one just accepted; ignore it this cycle.
    always_comb begin
        disp_eff    = disp_req & ~disp_ack;
        cmd_eff     = cmd_req & ~cmd_ack;
`ifdef VRAM_ARB_BLANK_GATE_EN
        cmd_allowed = cmd_eff & blank;
        starve_hit  = blank & (starve_cnt == STARVE_MAX);
`else
        cmd_allowed = cmd_eff;
        starve_hit  = (starve_cnt == STARVE_MAX);
`endif
        grant_cmd   = cmd_allowed & (~disp_eff | starve_hit);
        grant_disp  = disp_eff & ~grant_cmd;

        starve_nxt = 4'd0;
        if (cmd_eff && !grant_cmd) begin
            starve_nxt = (starve_cnt < STARVE_MAX) ? starve_cnt + 4'd1 : starve_cnt;
        end

        own1_nxt = OWN_NONE;
        if (grant_disp) begin
            own1_nxt = OWN_DISP;
        end else if (grant_cmd && !cmd_we) begin
            own1_nxt = OWN_CMD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_ack    <= 1'b0;
            cmd_ack     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            starve_cnt  <= 4'd0;
            own1        <= OWN_NONE;
            own2        <= OWN_NONE;
            disp_rvalid <= 1'b0;
            cmd_rvalid  <= 1'b0;
            disp_rdata  <= '0;
            cmd_rdata   <= '0;
        end else begin
            disp_ack   <= grant_disp;
            cmd_ack    <= grant_cmd;
            mem_en     <= grant_disp | grant_cmd;
            mem_we     <= grant_cmd & cmd_we;
            starve_cnt <= starve_nxt;
            if (grant_disp) begin
                mem_addr <= disp_addr;
            end else if (grant_cmd) begin
                mem_addr  <= cmd_addr;
                mem_wdata <= cmd_wdata;
            end
            // RAM data is valid the cycle after own2 is loaded, so own2 steers capture.
            own1        <= own1_nxt;
            own2        <= own1;
            disp_rvalid <= (own2 == OWN_DISP);
            cmd_rvalid  <= (own2 == OWN_CMD);
            if (own2 == OWN_DISP) begin
                disp_rdata <= mem_rdata;
            end
            if (own2 == OWN_CMD) begin
                cmd_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: RAM model, behavioural arbiter model with read scoreboards,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_vram_arb;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int STARVE = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
`ifdef VRAM_ARB_BLANK_GATE_EN
    logic          blank = 1'b1;
`endif
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_ack;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cmd_req = 1'b0;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ack;
    logic          cmd_rvalid;
    logic [DW-1:0] cmd_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    vram_arb dut (
        .clk(clk), .rst(rst),
`ifdef VRAM_ARB_BLANK_GATE_EN
        .blank(blank),
`endif
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ack(cmd_ack), .cmd_rvalid(cmd_rvalid), .cmd_rdata(cmd_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model and its reference copy ----------------
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 8'(i * 7 + 3);
        end
        ram[13'h0010] = 8'hA5;
        ram[13'h0001] = 8'h11;
        ram[13'h0002] = 8'h22;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = ram[i];
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- behavioural model ----------------
    int            cyc = 0;
    int            m_starve = 0;
    logic          e_disp_ack = 0, e_cmd_ack = 0, e_mem_en = 0, e_mem_we = 0;
    logic [AW-1:0] e_mem_addr = '0;
    logic [DW-1:0] e_mem_wdata = '0;
    logic          e_disp_rvalid = 0, e_cmd_rvalid = 0;
    logic [DW-1:0] e_disp_rdata = '0, e_cmd_rdata = '0;
    logic [39:0]   disp_exp_q[$];
    logic [39:0]   cmd_exp_q[$];

    always @(posedge clk or posedge rst) begin
        bit d, c, c_ok, ovr, gd, gc;
        if (rst) begin
            cyc = 0; m_starve = 0;
            e_disp_ack = 0; e_cmd_ack = 0; e_mem_en = 0; e_mem_we = 0;
            e_mem_addr = '0; e_mem_wdata = '0;
            e_disp_rvalid = 0; e_cmd_rvalid = 0; e_disp_rdata = '0; e_cmd_rdata = '0;
            disp_exp_q.delete(); cmd_exp_q.delete();
        end else begin
            cyc++;
            d = disp_req && !e_disp_ack;
            c = cmd_req && !e_cmd_ack;
`ifdef VRAM_ARB_BLANK_GATE_EN
            c_ok = c && blank;
            ovr  = blank && (m_starve == STARVE);
`else
            c_ok = c;
            ovr  = (m_starve == STARVE);
`endif
            gc = c_ok && (!d || ovr);
            gd = d && !gc;
            if (c && !gc) m_starve = (m_starve < STARVE) ? m_starve + 1 : m_starve;
            else          m_starve = 0;
            e_disp_ack = gd; e_cmd_ack = gc;
            e_mem_en = gd || gc;
            e_mem_we = gc && cmd_we;
            if (gd) begin
                e_mem_addr = disp_addr;
                disp_exp_q.push_back({32'(cyc + 2), ref_mem[disp_addr]});
            end
            if (gc) begin
                e_mem_addr = cmd_addr;
                e_mem_wdata = cmd_wdata;
                if (cmd_we) ref_mem[cmd_addr] = cmd_wdata;
                else        cmd_exp_q.push_back({32'(cyc + 2), ref_mem[cmd_addr]});
            end
            e_disp_rvalid = 0;
            if (disp_exp_q.size() > 0 && int'(disp_exp_q[0][39:8]) == cyc) begin
                e_disp_rvalid = 1; e_disp_rdata = disp_exp_q[0][7:0]; void'(disp_exp_q.pop_front());
            end
            e_cmd_rvalid = 0;
            if (cmd_exp_q.size() > 0 && int'(cmd_exp_q[0][39:8]) == cyc) begin
                e_cmd_rvalid = 1; e_cmd_rdata = cmd_exp_q[0][7:0]; void'(cmd_exp_q.pop_front());
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("disp_ack",    32'(disp_ack),    32'(e_disp_ack));
        chk("cmd_ack",     32'(cmd_ack),     32'(e_cmd_ack));
        chk("mem_en",      32'(mem_en),      32'(e_mem_en));
        chk("mem_we",      32'(mem_we),      32'(e_mem_we));
        chk("mem_addr",    32'(mem_addr),    32'(e_mem_addr));
        chk("mem_wdata",   32'(mem_wdata),   32'(e_mem_wdata));
        chk("disp_rvalid", 32'(disp_rvalid), 32'(e_disp_rvalid));
        chk("disp_rdata",  32'(disp_rdata),  32'(e_disp_rdata));
        chk("cmd_rvalid",  32'(cmd_rvalid),  32'(e_cmd_rvalid));
        chk("cmd_rdata",   32'(cmd_rdata),   32'(e_cmd_rdata));
        chk("starve_cnt",  32'(dut.starve_cnt), 32'(m_starve));
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input bit is_cmd, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_cmd ? cmd_ack : disp_ack) && n < 50);
        chk(is_cmd ? "cmd_ack_wait" : "disp_ack_wait", 32'(is_cmd ? cmd_ack : disp_ack), 32'd1);
    endtask

    task automatic disp_rd(input logic [AW-1:0] a);
        int n;
        disp_addr = a; disp_req = 1'b1;
        wait_ack(1'b0, n);
        disp_req = 1'b0;
    endtask

    task automatic cmd_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int n;
        cmd_we = we; cmd_addr = a; cmd_wdata = wd; cmd_req = 1'b1;
        wait_ack(1'b1, n);
        cmd_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_disp_rdata", 32'(disp_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Display read of a preloaded location.
        disp_rd(13'h0010);
        chk("d034_cmd_ack", 32'(cmd_ack), 32'd0);
        @(negedge clk);
        chk("d034_rvalid_early", 32'(disp_rvalid), 32'd0);
        @(negedge clk);
        chk("d034_rvalid", 32'(disp_rvalid), 32'd1);
        chk("d034_rdata", 32'(disp_rdata), 32'hA5);
        @(negedge clk);
        chk("d034_rvalid_pulse", 32'(disp_rvalid), 32'd0);
        chk("d034_rdata_hold", 32'(disp_rdata), 32'hA5);

        // Command write then read back.
        cmd_op(1'b1, 13'h0123, 8'h5A);
        chk("c035_mem_we", 32'(mem_we), 32'd1);
        chk("c035_mem_addr", 32'(mem_addr), 32'h0123);
        chk("c035_mem_wdata", 32'(mem_wdata), 32'h5A);
        repeat (2) begin
            @(negedge clk);
            chk("c035_no_wr_rvalid", 32'(cmd_rvalid), 32'd0);
        end
        cmd_op(1'b0, 13'h0123, 8'h00);
        chk("c035_rd_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("c035_rvalid", 32'(cmd_rvalid), 32'd1);
        chk("c035_rdata", 32'(cmd_rdata), 32'h5A);
        repeat (3) @(negedge clk);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h0123);

        // Simultaneous requests: display first, no cross-delivery.
        disp_addr = 13'h0001; disp_req = 1'b1;
        cmd_we = 1'b0; cmd_addr = 13'h0002; cmd_req = 1'b1;
        @(negedge clk);
        chk("s037_disp_first", 32'(disp_ack), 32'd1);
        chk("s037_cmd_wait", 32'(cmd_ack), 32'd0);
        disp_req = 1'b0;
        @(negedge clk);
        chk("s037_cmd_second", 32'(cmd_ack), 32'd1);
        cmd_req = 1'b0;
        @(negedge clk);
        chk("s037_disp_rvalid", 32'(disp_rvalid), 32'd1);
        chk("s037_disp_rdata", 32'(disp_rdata), 32'h11);
        chk("s037_cmd_quiet", 32'(cmd_rvalid), 32'd0);
        @(negedge clk);
        chk("s037_cmd_rvalid", 32'(cmd_rvalid), 32'd1);
        chk("s037_cmd_rdata", 32'(cmd_rdata), 32'h22);
        chk("s037_disp_quiet", 32'(disp_rvalid), 32'd0);
        repeat (2) @(negedge clk);

        // Display held continuously; command must still get through promptly.
        disp_addr = 13'h0010; disp_req = 1'b1;
        cmd_we = 1'b0; cmd_addr = 13'h0001; cmd_req = 1'b1;
        wait_ack(1'b1, n);
        cmd_req = 1'b0;
        chk("s036_latency_ok", 32'(n <= STARVE + 2), 32'd1);
        @(negedge clk);
        chk("s036_starve_clear", 32'(dut.starve_cnt), 32'd0);
        disp_req = 1'b0;
        repeat (4) @(negedge clk);

        // Reset one cycle after a display grant discards the read.
        disp_rd(13'h0010);
        rst = 1'b1;
        #1;
        chk("r038_disp_ack", 32'(disp_ack), 32'd0);
        chk("r038_mem_en", 32'(mem_en), 32'd0);
        chk("r038_mem_addr", 32'(mem_addr), 32'd0);
        chk("r038_disp_rdata", 32'(disp_rdata), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("r038_rvalid_in_rst", 32'(disp_rvalid), 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("r038_rvalid_after", 32'(disp_rvalid), 32'd0);
        end
        disp_rd(13'h0001);
        repeat (2) @(negedge clk);
        chk("r038_post_rdata", 32'(disp_rdata), 32'h11);
        @(negedge clk);

`ifdef VRAM_ARB_BLANK_GATE_EN
        // Command held through active video: no grant until blanking.
        blank = 1'b0;
        cmd_we = 1'b0; cmd_addr = 13'h0002; cmd_req = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("b039_no_ack", 32'(cmd_ack), 32'd0);
        end
        blank = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ack && n < 2);
        chk("b039_ack", 32'(cmd_ack), 32'd1);
        cmd_req = 1'b0;
        repeat (3) @(negedge clk);
`endif

        // Randomized traffic on a small address window so reads see earlier writes.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (disp_req && disp_ack) begin
                disp_req = 1'($urandom_range(0, 1));
            end else if (!disp_req) begin
                disp_req = ($urandom_range(0, 2) != 0);
                disp_addr = 13'($urandom_range(0, 31));
            end
            if (cmd_req && cmd_ack) begin
                cmd_req = 1'($urandom_range(0, 1));
            end else if (!cmd_req) begin
                cmd_req = ($urandom_range(0, 2) != 0);
                cmd_we = 1'($urandom_range(0, 1));
                cmd_addr = 13'($urandom_range(0, 31));
                cmd_wdata = 8'($urandom_range(0, 255));
            end
`ifdef VRAM_ARB_BLANK_GATE_EN
            if ($urandom_range(0, 15) == 0) blank = ~blank;
`endif
        end
        disp_req = 1'b0;
        cmd_req = 1'b0;
`ifdef VRAM_ARB_BLANK_GATE_EN
        blank = 1'b1;
`endif
        repeat (6) @(negedge clk);
        chk("drain_disp_q", 32'(disp_exp_q.size()), 32'd0);
        chk("drain_cmd_q", 32'(cmd_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
